bcp_imply_queue: RTL and testbench
==================================

# bcp_imply_queue

Unit-clause queue sitting directly downstream of the BCP processing element. It collects implied literals produced by the PE, checks each against a per-variable assignment table, and enqueues only new assignments in a first-word-fall-through FIFO. The PE pops that FIFO as its next propagation literal. The block also detects contradictory implications and latches a conflict for the search controller, which injects decision literals and flushes on backtrack.

## Interface
Parameters:
- LIT_W, 8, literal width; two's-complement signed; value 0 is reserved as "no literal"
- DEPTH, 16, FIFO entries (power of two)
- NVAR, 2**(LIT_W-1)-1, variables covered by the assignment table (indices 1..NVAR)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-high despite the name
- imply_valid  in  1  PE reports an implication this cycle
- imply_lit  in  LIT_W  implied literal
- pe_conflict  in  1  PE reports a conflicting clause
- dec_valid  in  1  controller offers a decision literal
- dec_lit  in  LIT_W  decision literal
- dec_ready  out  1  decision accepted this cycle
- clear  in  1  synchronous flush (backtrack)
- in_full  out  1  FIFO full; drives the PE's UCQ_in_full
- out_pop  in  1  PE consumes the head entry
- out_lit  out  LIT_W  head literal; 0 when empty
- out_empty  out  1  FIFO empty; drives the PE's UCQ_out_empty
- count  out  $clog2(DEPTH)+1  occupancy
- conflict  out  1  sticky contradiction flag
- overflow  out  1  sticky flag: a literal was dropped while full

## Operation
- Assignment table: two bits per variable, {assigned, value}. value=1 means the positive literal is true. var = |lit|.
- Candidate selection: if imply_valid=1 and imply_lit≠0, the candidate is imply_lit. Otherwise, if dec_valid=1 and dec_lit≠0, the candidate is dec_lit.
- dec_ready = !(imply_valid && imply_lit≠0) && !conflict && !clear.
- Candidate processing (skipped when conflict=1 or clear=1):
  - var unassigned: write the table entry and push the literal into the FIFO. If in_full=1, drop the literal, set overflow and leave the table untouched.
  - var assigned, same polarity: drop silently as a duplicate.
  - var assigned, opposite polarity: set conflict; no push, no table write.
- pe_conflict=1 sets conflict.
- Once conflict=1, all further pushes and table writes are ignored. Pops continue normally.
- Pop: when out_pop=1 and out_empty=0, advance the read pointer. A pop while empty is ignored.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, the push is still refused, because in_full is evaluated before the edge.
- clear: resets the pointers and count, the whole assignment table, conflict and overflow. It overrides every other input in the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert) values: out_lit=0, out_empty=1, in_full=0, count=0, conflict=0, overflow=0, dec_ready=1, all table entries unassigned.
- Combinational outputs:
  - in_full = (count==DEPTH)
  - out_empty = (count==0)
  - out_lit = FIFO head (FWFT), or 0 when empty
- Latency:
  - A literal accepted at edge N appears on out_lit after edge N (if the FIFO was empty) and raises count in cycle N+1.
  - The table write at edge N is visible to the candidate checked in cycle N+1, so back-to-back identical literals yield one push.
- conflict and overflow rise the cycle after the causing event and hold until clear or reset.
- clear takes effect at the next edge; all outputs reach reset values in the following cycle.
- Reset asserted mid-operation discards all FIFO contents and assignments immediately, without waiting for a clock edge.

## Test plan
- Reset, then imply 5 then −3 on consecutive cycles:
  - out_lit=5, count=2.
  - Pop once: out_lit=−3, count=1.
  - Pop again: out_empty=1, out_lit=0.
- Imply 7 on two consecutive cycles: exactly one push (count=1), conflict=0.
- Imply 4, then imply −4: conflict=1 the cycle after the −4, count stays 1. Assert clear: conflict=0, count=0, out_empty=1.
- Fill with literals 1..16 (DEPTH=16):
  - in_full=1 with count=16.
  - Imply 17: dropped, overflow=1, and variable 17 is still unassigned. Pop once, then imply 17: accepted.
- Drive imply 2 and dec 9 in the same cycle:
  - dec_ready=0 and only 2 is enqueued.
  - Next cycle with imply idle: dec_ready=1 and 9 is enqueued.
- Push and pop simultaneously at count=3: count stays 3 and the head advances. Assert rst_n between clock edges: out_empty=1 immediately.

Source files
------------

// File: rtl/bcp_imply_queue.sv
// Purpose: filters BCP implications and decisions through a per-variable assignment table into a FWFT literal FIFO.
// Latency: an accepted literal is on out_lit one edge after acceptance when the FIFO was empty; table writes are seen next cycle.
// Backpressure: in_full refuses pushes (literal dropped, overflow latched); conflict freezes pushes and table writes until clear.
module bcp_imply_queue #(
    parameter int LIT_W = 8,
    parameter int DEPTH = 16,
    parameter int NVAR  = 2**(LIT_W-1)-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imply_valid,
    input  logic [LIT_W-1:0] imply_lit,
    input  logic             pe_conflict,
    input  logic             dec_valid,
    input  logic [LIT_W-1:0] dec_lit,
    output logic             dec_ready,
    input  logic             clear,
    output logic             in_full,
    input  logic             out_pop,
    output logic [LIT_W-1:0] out_lit,
    output logic             out_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic             conflict,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = $clog2(NVAR+1);
    localparam logic [LIT_W:0] NVAR_W = (LIT_W+1)'(NVAR);

    logic [LIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;

    // Assignment table: asg_set marks an assigned variable, asg_val is the polarity of its true literal.
    logic [2**VW-1:0] asg_set;
    logic [2**VW-1:0] asg_val;

    logic             imply_act;
    logic             dec_act;
    logic             cand_vld;
    logic [LIT_W-1:0] cand_lit;
    logic             cand_neg;
    logic [LIT_W-1:0] cand_mag;
    logic [VW-1:0]    cand_var;
    logic             cand_in_range;
    logic             do_proc;
    logic             var_set;
    logic             same_pol;
    logic             push;
    logic             drop_full;
    logic             contra;
    logic             pop_ok;

    assign count     = cnt;
    assign in_full   = (cnt == (AW+1)'(DEPTH));
    assign out_empty = (cnt == '0);
    assign out_lit   = out_empty ? '0 : mem[rd_ptr];

    assign imply_act = imply_valid && (imply_lit != '0);
    assign dec_act   = dec_valid && (dec_lit != '0);
    assign dec_ready = !imply_act && !conflict && !clear;

    // Candidate selection and classification against the assignment table.
    always_comb begin
        cand_vld      = imply_act || dec_act;
        cand_lit      = imply_act ? imply_lit : dec_lit;
        cand_neg      = cand_lit[LIT_W-1];
        cand_mag      = cand_neg ? ('0 - cand_lit) : cand_lit;
        cand_var      = cand_mag[VW-1:0];
        // -2**(LIT_W-1) has no representable variable; such a literal is ignored.
        cand_in_range = ({1'b0, cand_mag} <= NVAR_W);
        do_proc       = cand_vld && cand_in_range && !conflict && !clear;
        var_set       = asg_set[cand_var];
        same_pol      = (asg_val[cand_var] == !cand_neg);
        push          = do_proc && !var_set && !in_full;
        drop_full     = do_proc && !var_set && in_full;
        contra        = do_proc && var_set && !same_pol;
        pop_ok        = out_pop && !out_empty && !clear;
    end

    // Pointers, occupancy, assignment table and sticky flags; clear behaves like a synchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            asg_set  <= '0;
            asg_val  <= '0;
            conflict <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            asg_set  <= '0;
            asg_val  <= '0;
            conflict <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                asg_set[cand_var] <= 1'b1;
                asg_val[cand_var] <= !cand_neg;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (contra || pe_conflict) begin
                conflict <= 1'b1;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cand_lit;
        end
    end
endmodule

// File: tb/tb_bcp_imply_queue.sv
module tb_bcp_imply_queue;
    localparam int LIT_W = 8;
    localparam int DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    imply_valid;
    logic signed [LIT_W-1:0] imply_lit;
    logic                    pe_conflict;
    logic                    dec_valid;
    logic signed [LIT_W-1:0] dec_lit;
    logic                    dec_ready;
    logic                    clear;
    logic                    in_full;
    logic                    out_pop;
    logic signed [LIT_W-1:0] out_lit;
    logic                    out_empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    conflict;
    logic                    overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of literals and a map var -> +1/-1.
    int mq[$];
    int masg[int];
    bit mconf;
    bit movf;

    bcp_imply_queue #(.LIT_W(LIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imply_valid(imply_valid), .imply_lit(imply_lit),
        .pe_conflict(pe_conflict),
        .dec_valid(dec_valid), .dec_lit(dec_lit), .dec_ready(dec_ready),
        .clear(clear), .in_full(in_full),
        .out_pop(out_pop), .out_lit(out_lit), .out_empty(out_empty),
        .count(count), .conflict(conflict), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        imply_valid = 0; imply_lit = 0; pe_conflict = 0;
        dec_valid = 0; dec_lit = 0; clear = 0; out_pop = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        masg.delete();
        mconf = 0;
        movf = 0;
    endtask

    // Advance one clock with the currently driven inputs, updating the model alongside.
    task automatic step();
        int cand;
        int v;
        int sgn;
        bit was_full;
        bit was_empty;
        cand = 0;
        was_full = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (imply_valid && imply_lit != 0) cand = int'(imply_lit);
        else if (dec_valid && dec_lit != 0) cand = int'(dec_lit);
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else begin
            if (out_pop && !was_empty) void'(mq.pop_front());
            if (cand != 0 && !mconf) begin
                v = (cand < 0) ? -cand : cand;
                sgn = (cand < 0) ? -1 : 1;
                if (!masg.exists(v)) begin
                    if (was_full) movf = 1;
                    else begin
                        mq.push_back(cand);
                        masg[v] = sgn;
                    end
                end else if (masg[v] != sgn) begin
                    mconf = 1;
                end
            end
            if (pe_conflict) mconf = 1;
        end
        #1;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic imply(input int lit);
        idle_inputs();
        imply_valid = 1;
        imply_lit = lit[LIT_W-1:0];
        step();
        idle_inputs();
    endtask

    task automatic pop();
        idle_inputs();
        out_pop = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1;
        #12;
        model_reset();
        checks++;
        if (out_empty !== 1 || in_full !== 0 || count !== 0 || out_lit !== 0 ||
            conflict !== 0 || overflow !== 0 || dec_ready !== 1) begin
            errors++;
            $display("FAIL reset: empty=%0b full=%0b count=%0d lit=%0d conf=%0b ovf=%0b rdy=%0b, required 1 0 0 0 0 0 1",
                     out_empty, in_full, count, out_lit, conflict, overflow, dec_ready);
        end
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        imply(5);
        imply(-3);
        checks++;
        if (out_lit !== 8'sd5 || count !== 2) begin
            errors++;
            $display("FAIL basic_push: out_lit=%0d count=%0d, required 5 2", out_lit, count);
        end
        pop();
        checks++;
        if (out_lit !== -8'sd3 || count !== 1) begin
            errors++;
            $display("FAIL basic_pop1: out_lit=%0d count=%0d, required -3 1", out_lit, count);
        end
        pop();
        checks++;
        if (out_empty !== 1 || out_lit !== 0) begin
            errors++;
            $display("FAIL basic_pop2: empty=%0b out_lit=%0d, required 1 0", out_empty, out_lit);
        end
    endtask

    task automatic test_duplicate();
        do_clear();
        imply(7);
        imply(7);
        checks++;
        if (count !== 1 || conflict !== 0) begin
            errors++;
            $display("FAIL duplicate: count=%0d conflict=%0b, required 1 0", count, conflict);
        end
    endtask

    task automatic test_conflict();
        do_clear();
        imply(4);
        imply(-4);
        checks++;
        if (conflict !== 1 || count !== 1) begin
            errors++;
            $display("FAIL conflict: conflict=%0b count=%0d, required 1 1", conflict, count);
        end
        checks++;
        if (dec_ready !== 0) begin
            errors++;
            $display("FAIL conflict_rdy: dec_ready=%0b, required 0", dec_ready);
        end
        do_clear();
        checks++;
        if (conflict !== 0 || count !== 0 || out_empty !== 1) begin
            errors++;
            $display("FAIL clear: conflict=%0b count=%0d empty=%0b, required 0 0 1", conflict, count, out_empty);
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 1; i <= DEPTH; i++) imply(i);
        checks++;
        if (in_full !== 1 || count !== DEPTH) begin
            errors++;
            $display("FAIL full: in_full=%0b count=%0d, required 1 %0d", in_full, count, DEPTH);
        end
        imply(17);
        checks++;
        if (overflow !== 1 || count !== DEPTH) begin
            errors++;
            $display("FAIL overflow: overflow=%0b count=%0d, required 1 %0d", overflow, count, DEPTH);
        end
        pop();
        imply(17);
        checks++;
        if (count !== DEPTH || out_lit !== 8'sd2 || overflow !== 1) begin
            errors++;
            $display("FAIL refill: count=%0d out_lit=%0d ovf=%0b, required %0d 2 1", count, out_lit, overflow, DEPTH);
        end
        // Drain to confirm 17 landed at the tail after wrap.
        for (int i = 0; i < DEPTH - 1; i++) pop();
        checks++;
        if (out_lit !== 8'sd17 || count !== 1) begin
            errors++;
            $display("FAIL wrap_tail: out_lit=%0d count=%0d, required 17 1", out_lit, count);
        end
    endtask

    task automatic test_priority();
        do_clear();
        idle_inputs();
        imply_valid = 1; imply_lit = 2;
        dec_valid = 1; dec_lit = 9;
        #1;
        checks++;
        if (dec_ready !== 0) begin
            errors++;
            $display("FAIL prio_rdy0: dec_ready=%0b, required 0", dec_ready);
        end
        step();
        checks++;
        if (count !== 1 || out_lit !== 8'sd2) begin
            errors++;
            $display("FAIL prio_imply: count=%0d out_lit=%0d, required 1 2", count, out_lit);
        end
        imply_valid = 0; imply_lit = 0;
        #1;
        checks++;
        if (dec_ready !== 1) begin
            errors++;
            $display("FAIL prio_rdy1: dec_ready=%0b, required 1", dec_ready);
        end
        step();
        idle_inputs();
        pop();
        checks++;
        if (count !== 1 || out_lit !== 8'sd9) begin
            errors++;
            $display("FAIL prio_dec: count=%0d out_lit=%0d, required 1 9", count, out_lit);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        imply(10); imply(11); imply(12);
        idle_inputs();
        imply_valid = 1; imply_lit = 13; out_pop = 1;
        step();
        idle_inputs();
        checks++;
        if (count !== 3 || out_lit !== 8'sd11) begin
            errors++;
            $display("FAIL push_pop: count=%0d out_lit=%0d, required 3 11", count, out_lit);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1;
        #1;
        checks++;
        if (out_empty !== 1 || count !== 0) begin
            errors++;
            $display("FAIL async_rst: empty=%0b count=%0d, required 1 0", out_empty, count);
        end
        #1;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        imply(12);
        checks++;
        if (count !== 1 || out_lit !== 8'sd12) begin
            errors++;
            $display("FAIL post_rst_table: count=%0d out_lit=%0d, required 1 12", count, out_lit);
        end
    endtask

    task automatic test_random();
        int exp_lit;
        bit exp_rdy;
        do_clear();
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            imply_valid = ($urandom_range(0, 3) != 0);
            imply_lit = 8'($urandom_range(0, 40)) - 8'sd20;
            dec_valid = $urandom_range(0, 1);
            dec_lit = 8'($urandom_range(0, 40)) - 8'sd20;
            out_pop = ($urandom_range(0, 2) == 0);
            pe_conflict = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 39) == 0);
            #1;
            exp_rdy = !(imply_valid && imply_lit != 0) && !mconf && !clear;
            checks++;
            if (dec_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_rdy[%0d]: dec_ready=%0b, required %0b", n, dec_ready, exp_rdy);
            end
            step();
            exp_lit = (mq.size() != 0) ? mq[0] : 0;
            checks++;
            if (int'(out_lit) !== exp_lit || int'(count) !== mq.size() ||
                out_empty !== (mq.size() == 0) || in_full !== (mq.size() == DEPTH) ||
                conflict !== mconf || overflow !== movf) begin
                errors++;
                $display("FAIL rnd_state[%0d]: lit=%0d cnt=%0d conf=%0b ovf=%0b, required %0d %0d %0b %0b",
                         n, out_lit, count, conflict, overflow, exp_lit, mq.size(), mconf, movf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        test_reset();
        test_basic();
        test_duplicate();
        test_conflict();
        test_full();
        test_priority();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
